// File: rtl/div_pkg.sv
// Shared definitions for the divider chain: measurement FSM states, default sizing, clogb2.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_STUCK = 2'd3
    } state_e;

    localparam int unsigned DEF_CW      = 8;
    localparam int unsigned DEF_TIMEOUT = 255;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned res;
        longint unsigned pow;
        res = 0;
        pow = 1;
        while (pow < longint'(value)) begin
            pow = pow << 1;
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_meas_edge_sync.sv
// Input stage for div_meas: sampling register, delayed copy and rising-edge detect.
// Macro DIV_MEAS_SYNC_EN adds a 2-flop synchronizer ahead of the sampling register.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic s,
    output logic rise
);

    logic s_in;
    logic s_q, s_d;
    logic s_dly_q, s_dly_d;

`ifdef DIV_MEAS_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], sig_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s_in = sync_q[1];
`else
    assign s_in = sig_in;
`endif

    always_comb begin
        s_d     = s_in;
        s_dly_d = s_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= 1'b0;
            s_dly_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            s_dly_q <= s_dly_d;
        end
    end

    assign s    = s_q;
    assign rise = s_q & ~s_dly_q;

endmodule

// File: rtl/div_meas.sv
// Period / high-time / lock / stuck monitor for a slow divider output sampled in the clk domain.
// Macro DIV_MEAS_SYNC_EN: synchronize an asynchronous sig_in (adds 2 cycles of latency).
module div_meas
    import div_pkg::*;
#(
    parameter int unsigned CW      = DEF_CW,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sig_in,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_cnt,
    output logic          meas_valid,
    output logic          locked,
    output logic          stuck
);

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    logic s;
    logic rise;

    state_e        state_q, state_d;
    logic [CW-1:0] per_cnt_q, per_cnt_d;
    logic [CW-1:0] hi_cnt_q, hi_cnt_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] high_q, high_d;
    logic          meas_valid_q, meas_valid_d;
    logic          locked_q, locked_d;
    logic          stuck_q, stuck_d;
    logic          publish;

    edge_sync u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .s      (s),
        .rise   (rise)
    );

    always_comb begin
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        if (rise) begin
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
        end else begin
            if (per_cnt_q != CNT_MAX) begin
                per_cnt_d = per_cnt_q + CNT_ONE;
            end
            if (s && (hi_cnt_q != CNT_MAX)) begin
                hi_cnt_d = hi_cnt_q + CNT_ONE;
            end
        end
    end

    // A rise always wins over the timeout, so period == TIMEOUT is still published.
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        high_d       = high_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        stuck_d      = stuck_q;
        publish      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM, ST_RUN: begin
                if (rise) begin
                    publish = 1'b1;
                    state_d = ST_RUN;
                end else if (per_cnt_q == TIMEOUT_C) begin
                    state_d  = ST_STUCK;
                    stuck_d  = 1'b1;
                    locked_d = 1'b0;
                end
            end
            ST_STUCK: begin
                if (rise) begin
                    state_d = ST_ARM;
                    stuck_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (publish) begin
            period_d     = per_cnt_q;
            high_d       = hi_cnt_q;
            meas_valid_d = 1'b1;
            locked_d     = (per_cnt_q == period_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            per_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            period_q     <= '0;
            high_q       <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_cnt_q    <= per_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            period_q     <= period_d;
            high_q       <= high_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            stuck_q      <= stuck_d;
        end
    end

    assign period     = period_q;
    assign high_cnt   = high_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign stuck      = stuck_q;

endmodule
